// File: rtl/wb_byte_bridge_pkg.sv
// Shared FSM states, status codes and command fields
// for the byte-serial to Wishbone bridge.
package wb_byte_bridge_pkg;

  typedef enum logic [3:0] {
    S_CMD  = 4'd0,
    S_ADR0 = 4'd1,
    S_ADR1 = 4'd2,
    S_D0   = 4'd3,
    S_D1   = 4'd4,
    S_D2   = 4'd5,
    S_D3   = 4'd6,
    S_BUS  = 4'd7,
    S_STAT = 4'd8,
    S_RD0  = 4'd9,
    S_RD1  = 4'd10,
    S_RD2  = 4'd11,
    S_RD3  = 4'd12
  } state_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

  localparam int CMD_WE_BIT = 7;

endpackage

// File: rtl/wb_byte_bridge.sv
// Byte stream host to classic Wishbone master: cmd, addr, data in;
// status (+ read data) out. Ports: clk/rst_n, in_*, out_*, wb_*, busy.
module wb_byte_bridge #(
  parameter int ADR_W   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             wb_CYC,
  output logic             wb_STB,
  output logic             wb_WE,
  output logic [ADR_W-1:0] wb_ADR,
  output logic [3:0]       wb_SEL,
  output logic [31:0]      wb_DAT_MOSI,
  input  logic [31:0]      wb_DAT_MISO,
  input  logic             wb_ACK,
  output logic             busy
);

  import wb_byte_bridge_pkg::*;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [3:0]         r_sel;
  logic [ADR_W-1:0]   r_adr;
  logic [31:0]        r_dat;
  logic [7:0]         r_cnt;
  logic               r_to;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_expire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_expire   = (r_cnt >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CMD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CMD:  if (w_in_fire) w_next = S_ADR0;
      S_ADR0: if (w_in_fire) w_next = S_ADR1;
      S_ADR1:
        if (w_in_fire) w_next = r_we ? S_D0 : S_BUS;
      S_D0:   if (w_in_fire) w_next = S_D1;
      S_D1:   if (w_in_fire) w_next = S_D2;
      S_D2:   if (w_in_fire) w_next = S_D3;
      S_D3:   if (w_in_fire) w_next = S_BUS;
      // ACK takes priority over an expiring counter
      S_BUS:
        if (wb_ACK || w_expire) w_next = S_STAT;
      S_STAT:
        if (w_out_fire)
          w_next = (!r_we && !r_to) ? S_RD0 : S_CMD;
      S_RD0:  if (w_out_fire) w_next = S_RD1;
      S_RD1:  if (w_out_fire) w_next = S_RD2;
      S_RD2:  if (w_out_fire) w_next = S_RD3;
      S_RD3:  if (w_out_fire) w_next = S_CMD;
      default: w_next = S_CMD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    wb_CYC    = 1'b0;
    wb_STB    = 1'b0;
    busy      = (r_state != S_CMD);
    unique case (r_state)
      S_CMD, S_ADR0, S_ADR1,
      S_D0, S_D1, S_D2, S_D3:
        in_ready = 1'b1;
      S_BUS: begin
        wb_CYC = 1'b1;
        wb_STB = 1'b1;
      end
      S_STAT: begin
        out_valid = 1'b1;
        out_data  = r_to ? STATUS_TIMEOUT : STATUS_OK;
      end
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        out_valid = 1'b1;
        out_data  = r_dat[7:0];
      end
      default: ;
    endcase
  end

  // r_dat shifts right: write bytes enter at the top so D0
  // ends at [7:0]; read bytes leave from [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_sel <= 4'h0;
      r_adr <= '0;
      r_dat <= 32'h0;
      r_cnt <= 8'h0;
      r_to  <= 1'b0;
    end else begin
      if (r_state != S_BUS) r_cnt <= 8'h0;
      unique case (r_state)
        S_CMD: if (w_in_fire) begin
          r_we  <= in_data[CMD_WE_BIT];
          r_sel <= in_data[3:0];
        end
        S_ADR0: if (w_in_fire) r_adr[7:0] <= in_data;
        S_ADR1: if (w_in_fire)
          r_adr[ADR_W-1:8] <= in_data[ADR_W-9:0];
        S_D0, S_D1, S_D2, S_D3:
          if (w_in_fire) r_dat <= {in_data, r_dat[31:8]};
        S_BUS: begin
          if (wb_ACK) begin
            r_to <= 1'b0;
            if (!r_we) r_dat <= wb_DAT_MISO;
          end else if (w_expire) begin
            r_to <= 1'b1;
          end
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
        S_RD0, S_RD1, S_RD2, S_RD3:
          if (w_out_fire) r_dat <= {8'h00, r_dat[31:8]};
        default: ;
      endcase
    end
  end

  assign wb_WE       = r_we;
  assign wb_ADR      = r_adr;
  assign wb_SEL      = r_sel;
  assign wb_DAT_MOSI = r_dat;

endmodule

// File: tb/tb_wb_byte_bridge.sv
// Scoreboard bench for wb_byte_bridge: two instances
// (timeout 255 and 4), one active at a time.
module tb_wb_byte_bridge;

  localparam int TO_A = 255;
  localparam int TO_B = 4;

  typedef struct {
    logic        we;
    logic [13:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          len;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] miso = 32'h0;
  logic        sel = 1'b0;

  logic        a_ir, a_ov, a_cyc, a_stb, a_we, a_busy;
  logic [7:0]  a_od;
  logic [13:0] a_adr;
  logic [3:0]  a_sel;
  logic [31:0] a_mosi;
  logic        b_ir, b_ov, b_cyc, b_stb, b_we, b_busy;
  logic [7:0]  b_od;
  logic [13:0] b_adr;
  logic [3:0]  b_sel;
  logic [31:0] b_mosi;

  logic        m_ir, m_ov, m_cyc, m_stb, m_we, m_busy;
  logic [7:0]  m_od;
  logic [13:0] m_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_mosi;

  wb_byte_bridge #(.ADR_W(14), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od),
    .out_ready(out_ready & ~sel),
    .wb_CYC(a_cyc), .wb_STB(a_stb), .wb_WE(a_we),
    .wb_ADR(a_adr), .wb_SEL(a_sel), .wb_DAT_MOSI(a_mosi),
    .wb_DAT_MISO(miso), .wb_ACK(ack & ~sel),
    .busy(a_busy)
  );

  wb_byte_bridge #(.ADR_W(14), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od),
    .out_ready(out_ready & sel),
    .wb_CYC(b_cyc), .wb_STB(b_stb), .wb_WE(b_we),
    .wb_ADR(b_adr), .wb_SEL(b_sel), .wb_DAT_MOSI(b_mosi),
    .wb_DAT_MISO(miso), .wb_ACK(ack & sel),
    .busy(b_busy)
  );

  assign m_ir   = sel ? b_ir   : a_ir;
  assign m_ov   = sel ? b_ov   : a_ov;
  assign m_od   = sel ? b_od   : a_od;
  assign m_cyc  = sel ? b_cyc  : a_cyc;
  assign m_stb  = sel ? b_stb  : a_stb;
  assign m_we   = sel ? b_we   : a_we;
  assign m_adr  = sel ? b_adr  : a_adr;
  assign m_sel  = sel ? b_sel  : a_sel;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_busy = sel ? b_busy : a_busy;

  int          n_chk = 0;
  int          n_pass = 0;
  txn_t        wbq[$];
  logic [7:0]  expq[$];
  txn_t        cur;
  bit          in_bus = 0;
  int          ccnt = 0;
  int          scnt = 0;
  int          ack_delay = 0;
  logic [31:0] miso_val = 32'h0;
  bit          stray_en = 0;
  bit          force_stall = 0;
  bit          held_v = 0;
  logic [7:0]  held_d = 8'h00;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic fail(input string nm, input int act);
    n_chk++;
    $display("FAIL %s: got %0d expected none", nm, act);
  endtask

  // Wishbone slave: ACK in STB cycle ack_delay+1
  initial forever begin
    @(negedge clk);
    if (m_cyc && m_stb) begin
      scnt++;
      ack = (scnt == ack_delay + 1);
    end else begin
      scnt = 0;
      ack = stray_en && ($urandom_range(0, 3) == 0);
    end
    miso = ack ? miso_val : $urandom;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (force_stall) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (held_v)
      chk("out_hold", {23'h0, m_ov, m_od},
          {23'h0, 1'b1, held_d});
    if (m_ov && out_ready) begin
      if (expq.size() == 0) fail("out_extra", m_od);
      else chk("out_byte", m_od, expq.pop_front());
    end
    held_v = m_ov && !out_ready;
    held_d = m_od;
  end

  // Bus monitor
  initial forever begin
    @(negedge clk);
    if (m_cyc) begin
      if (!in_bus) begin
        in_bus = 1;
        ccnt = 1;
        if (wbq.size() == 0) begin
          fail("wb_extra", m_adr);
          cur.len = -1;
        end else begin
          cur = wbq.pop_front();
          chk("wb_sel", m_sel, cur.sel);
          chk("wb_we", m_we, cur.we);
          if (cur.we) chk("wb_mosi", m_mosi, cur.dat);
        end
      end else begin
        ccnt++;
      end
      chk("wb_stb", m_stb, 1);
      chk("wb_adr", m_adr, cur.adr);
    end else if (in_bus) begin
      in_bus = 0;
      chk("stb_drop", m_stb, 0);
      chk("cyc_len", ccnt, cur.len);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (m_ir) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) fail("in_hs_timeout", b);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && wbq.size() == 0 &&
          !in_bus && !m_busy)
        done = 1;
    end
    if (!done) fail("idle_timeout", expq.size());
  endtask

  task automatic run_txn(input bit          which,
                         input logic [7:0]  cmd,
                         input logic [7:0]  a0,
                         input logic [7:0]  a1,
                         input logic [31:0] wdat,
                         input int          dly,
                         input logic [31:0] rdat,
                         input bit          wait_done);
    int         to;
    bit         ok;
    txn_t       t;
    logic [7:0] bytes[$];
    to    = which ? TO_B : TO_A;
    ok    = (dly + 1 <= to);
    t.we  = cmd[7];
    t.sel = cmd[3:0];
    t.adr = {a1[5:0], a0};
    t.dat = wdat;
    t.len = ok ? dly + 1 : to;
    @(posedge clk);
    #1;
    sel       = which;
    ack_delay = dly;
    miso_val  = rdat;
    wbq.push_back(t);
    expq.push_back(ok ? 8'h00 : 8'h01);
    if (ok && !t.we)
      for (int i = 0; i < 4; i++)
        expq.push_back(rdat[8*i +: 8]);
    bytes = {cmd, a0, a1};
    if (t.we)
      for (int i = 0; i < 4; i++)
        bytes.push_back(wdat[8*i +: 8]);
    foreach (bytes[i]) send_byte(bytes[i]);
    if (wait_done) wait_idle();
  endtask

  initial begin
    bit         seen;
    bit         which;
    int         d;
    logic [7:0] cmd;

    #1;
    chk("rst_in_ready", m_ir, 1);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_out_data", m_od, 0);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_adr", m_adr, 0);
    chk("rst_mosi", m_mosi, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_txn(0, 8'h8F, 8'h04, 8'h01, 32'h12345678,
            0, 32'h0, 1);
    run_txn(0, 8'h03, 8'h10, 8'h00, 32'h0,
            3, 32'hDEADBEEF, 1);
    run_txn(0, 8'h0F, 8'h00, 8'h00, 32'h0,
            1000, 32'h0, 1);

    force_stall = 1;
    run_txn(0, 8'h0F, 8'hFF, 8'hFF, 32'h0,
            0, $urandom, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (m_ov) seen = 1;
    end
    if (!seen) fail("stall_wait", 0);
    repeat (10) @(posedge clk);
    force_stall = 0;
    wait_idle();

    run_txn(0, 8'h0F, 8'h00, 8'h00, 32'h0,
            1000, 32'h0, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (m_cyc) seen = 1;
    end
    if (!seen) fail("cyc_wait", 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", m_cyc, 0);
    chk("arst_stb", m_stb, 0);
    chk("arst_busy", m_busy, 0);
    chk("arst_in_ready", m_ir, 1);
    chk("arst_out_valid", m_ov, 0);
    expq.delete();
    wbq.delete();
    in_bus = 0;
    held_v = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(0, 8'h0F, 8'h00, 8'h00, 32'h0,
            2, $urandom, 1);

    run_txn(1, 8'h0F, 8'h00, 8'h00, 32'h0,
            3, 32'hCAFEF00D, 1);
    run_txn(1, 8'h0F, 8'h00, 8'h00, 32'h0,
            4, 32'h0, 1);

    stray_en = 1;
    for (int n = 0; n < 30; n++) begin
      which = ($urandom_range(0, 3) == 0);
      cmd = {1'($urandom), 3'($urandom), 4'($urandom)};
      if (which) d = $urandom_range(0, 6);
      else if ($urandom_range(0, 9) == 0) d = 300;
      else d = $urandom_range(0, 8);
      run_txn(which, cmd, 8'($urandom), 8'($urandom),
              $urandom, d, $urandom, 1);
    end

    chk("end_expq", expq.size(), 0);
    chk("end_wbq", wbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
